// File: rtl/collision_scanner.sv
// Snapshots the player and N_ENEMY enemy boxes on start, then tests one enemy per cycle for AABB overlap.
// Results are published as a set with a one-cycle done pulse; start is ignored while busy.
module collision_scanner #(
    parameter int COORD_W     = 10,
    parameter int N_ENEMY     = 4,
    parameter int P_SIZE      = 16,
    parameter int E_SIZE      = 16,
    parameter int BLOCK_SHIFT = 4,
    parameter int IDX_W       = $clog2(N_ENEMY)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [2*COORD_W-1:0]              position,
    input  logic [N_ENEMY*2*COORD_W-1:0]      e_positions,
    input  logic [N_ENEMY-1:0]                e_valid,
    output logic                              busy,
    output logic                              done,
    output logic [N_ENEMY-1:0]                hit_mask,
    output logic                              any_hit,
    output logic [IDX_W-1:0]                  first_hit,
    output logic [COORD_W-BLOCK_SHIFT-1:0]    pblock_x,
    output logic [COORD_W-BLOCK_SHIFT-1:0]    pblock_y
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [2*COORD_W-1:0]           snap_pos;
    logic [N_ENEMY*2*COORD_W-1:0]   snap_epos;
    logic [N_ENEMY-1:0]             snap_valid;
    logic [N_ENEMY-1:0]             work_mask;
    logic [N_ENEMY-1:0]             mask_nxt;
    logic [IDX_W-1:0]               idx;
    logic [IDX_W-1:0]               first_nxt;
    logic                           last;
    logic                           hit_now;
    logic [COORD_W-1:0]             px, py, ex, ey;
    logic [COORD_W:0]               px_end, py_end, ex_end, ey_end;

    assign px = snap_pos[2*COORD_W-1:COORD_W];
    assign py = snap_pos[COORD_W-1:0];

    always_comb begin
        ex = snap_epos[int'(idx)*2*COORD_W + COORD_W +: COORD_W];
        ey = snap_epos[int'(idx)*2*COORD_W +: COORD_W];
    end

    // One extra bit on every sum so boxes at the far edge never wrap onto 0.
    assign px_end = {1'b0, px} + (COORD_W+1)'(P_SIZE);
    assign py_end = {1'b0, py} + (COORD_W+1)'(P_SIZE);
    assign ex_end = {1'b0, ex} + (COORD_W+1)'(E_SIZE);
    assign ey_end = {1'b0, ey} + (COORD_W+1)'(E_SIZE);

    assign hit_now = snap_valid[idx]
                   && ({1'b0, ex} <= px_end) && ({1'b0, px} <= ex_end)
                   && ({1'b0, ey} <= py_end) && ({1'b0, py} <= ey_end);

    assign last = (idx == IDX_W'(N_ENEMY-1));
    assign busy = (state != IDLE);

    always_comb begin
        mask_nxt      = work_mask;
        mask_nxt[idx] = hit_now;
    end

    always_comb begin
        first_nxt = '0;
        for (int i = N_ENEMY-1; i >= 0; i--) begin
            if (mask_nxt[i]) first_nxt = IDX_W'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last)  state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Outputs load on the last SCAN edge so they are already visible while in REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_pos   <= '0;
            snap_epos  <= '0;
            snap_valid <= '0;
            work_mask  <= '0;
            idx        <= '0;
            done       <= 1'b0;
            hit_mask   <= '0;
            any_hit    <= 1'b0;
            first_hit  <= '0;
            pblock_x   <= '0;
            pblock_y   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_pos   <= position;
                        snap_epos  <= e_positions;
                        snap_valid <= e_valid;
                        work_mask  <= '0;
                        idx        <= '0;
                    end
                end
                SCAN: begin
                    work_mask <= mask_nxt;
                    if (last) begin
                        hit_mask  <= mask_nxt;
                        any_hit   <= |mask_nxt;
                        first_hit <= first_nxt;
                        pblock_x  <= px[COORD_W-1:BLOCK_SHIFT];
                        pblock_y  <= py[COORD_W-1:BLOCK_SHIFT];
                        done      <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/collision_scanner.md
# collision_scanner

Sequential, parametrised player-vs-enemy collision checker for the RPG game logic. It snapshots the player position and up to N_ENEMY enemy positions on a start pulse, then tests one enemy per cycle using axis-aligned bounding-box overlap with configurable sprite sizes. It reports a per-enemy hit mask, an any-hit flag, the lowest-index hit and the player's tile coordinates. It sits between the movement/enemy-AI logic and the game-state controller, replacing the single-enemy combinational check.

## Interface
- COORD_W, 10, width of one coordinate (x or y)
- N_ENEMY, 4, number of enemy slots (>= 2)
- P_SIZE, 16, player sprite extent in pixels (both axes)
- E_SIZE, 16, enemy sprite extent in pixels (both axes)
- BLOCK_SHIFT, 4, log2 of tile size for tile-coordinate outputs
- IDX_W, $clog2(N_ENEMY), width of enemy index

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a scan; honoured only in IDLE
- position  in  2*COORD_W  player position; x = [2*COORD_W-1:COORD_W], y = [COORD_W-1:0]
- e_positions  in  N_ENEMY*2*COORD_W  packed enemy positions; enemy i at [i*2*COORD_W +: 2*COORD_W], same x/y split
- e_valid  in  N_ENEMY  enemy slot i is alive; invalid slots never hit
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when results update
- hit_mask  out  N_ENEMY  bit i set if enemy i overlapped
- any_hit  out  1  OR of hit_mask
- first_hit  out  IDX_W  lowest set index of hit_mask; 0 when none
- pblock_x  out  COORD_W-BLOCK_SHIFT  snapshot player x >> BLOCK_SHIFT
- pblock_y  out  COORD_W-BLOCK_SHIFT  snapshot player y >> BLOCK_SHIFT

## Operation
- States: IDLE, SCAN, REPORT.
- IDLE: on start=1, capture position, e_positions and e_valid into snapshot registers; clear working mask; idx=0; go SCAN. Inputs may change freely after the capture cycle.
- SCAN: evaluate enemy idx from snapshot; write result into working mask bit idx; if idx == N_ENEMY-1 go REPORT, else idx++.
- Overlap test (closed intervals, edges touching counts as hit): ex <= px+P_SIZE and px <= ex+E_SIZE and ey <= py+P_SIZE and py <= ey+E_SIZE and valid. All sums computed at COORD_W+1 bits; no wrap-around, so a coordinate near 2^COORD_W-1 never aliases to 0.
- REPORT: load hit_mask, any_hit, first_hit (priority encode, lowest index), pblock_x, pblock_y from working/snapshot state; assert done; go IDLE.
- Output registers hold their values until the next REPORT.
- start while busy: ignored, not queued.
- start in the same cycle as rst: rst wins.

## Timing
- Reset values: state IDLE, busy=0, done=0, hit_mask=0, any_hit=0, first_hit=0, pblock_x=0, pblock_y=0, idx=0.
- start sampled high in IDLE at edge t; busy=1 from t+1; SCAN occupies N_ENEMY cycles; done=1 and new results visible in cycle t+N_ENEMY+1; busy=0 from t+N_ENEMY+2.
- Earliest restart: start asserted in the cycle after done is accepted, i.e. scan period N_ENEMY+2 cycles.
- rst mid-scan: next cycle is IDLE with all outputs at reset values; the partial scan is discarded and done is not pulsed.

## Test plan
- Reset: hold rst 2 cycles -> all outputs 0, busy=0; start with rst=1 -> no scan.
- Touch boundary, defaults: player (100,100), enemy0 (116,116) valid -> hit_mask=0001, any_hit=1, first_hit=0; enemy0 at (117,100) -> hit_mask=0000, any_hit=0.
- Multi-hit priority: enemies 1 and 3 at (90,95), 0 and 2 far, all valid -> hit_mask=1010, first_hit=1, done exactly 5 cycles after start (N_ENEMY=4).
- Masking: same as previous but e_valid=0111 -> hit_mask=0010; pblock_x=6, pblock_y=6 for player (100,100).
- Edge coordinates: player (1015,1015), enemy (0,0) -> no hit (no wrap); start re-pulsed during busy -> exactly one done.
- Reset mid-scan: assert rst 2 cycles after start -> no done pulse, outputs 0; a fresh scan afterwards completes normally.
